// File: rtl/wb_pkg.sv
// Shared writeback definitions: FSM state encoding and lo-source select codes.
// Also imported by the decode-stage hazard unit.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SINGLE  = 2'd1,
        DUAL_LO = 2'd2,
        DUAL_HI = 2'd3
    } wb_state_e;

    localparam int SRC_W = 2;

    localparam logic [SRC_W-1:0] SRC_ALU  = 2'b00;
    localparam logic [SRC_W-1:0] SRC_MEM  = 2'b01;
    localparam logic [SRC_W-1:0] SRC_PORT = 2'b10;
    localparam logic [SRC_W-1:0] SRC_IMM  = 2'b11;

endpackage

// File: rtl/writeback_sequencer_if.sv
// MEM/WB -> WB handshake: one retiring instruction with all candidate data.
interface writeback_sequencer_if
    import wb_pkg::*;
#(
    parameter int REG_SIZE = 16,
    parameter int ADDR_W   = 3
);
    logic                in_valid;
    logic                in_ready;
    logic                in_wb_en;
    logic                in_dual;
    logic [SRC_W-1:0]    in_src_sel;
    logic [ADDR_W-1:0]   in_dst;
    logic [REG_SIZE-1:0] in_alu_lo;
    logic [REG_SIZE-1:0] in_alu_hi;
    logic [REG_SIZE-1:0] in_mem_data;
    logic [REG_SIZE-1:0] in_port_data;
    logic [REG_SIZE-1:0] in_imm;

    modport master (
        output in_valid, in_wb_en, in_dual, in_src_sel, in_dst,
               in_alu_lo, in_alu_hi, in_mem_data, in_port_data, in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_wb_en, in_dual, in_src_sel, in_dst,
               in_alu_lo, in_alu_hi, in_mem_data, in_port_data, in_imm,
        output in_ready
    );
endinterface

// File: rtl/writeback_sequencer_wrap_counter.sv
// Free-running wrap-around event counter with synchronous active-low reset.
module wrap_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/writeback_sequencer.sv
// WB stage: drives the register-file write port, splitting dual-result
// instructions into lo/hi writes on consecutive cycles.
module writeback_sequencer
    import wb_pkg::*;
#(
    parameter int REG_SIZE   = 16,
    parameter int REG_NUMBER = 8,
    parameter int CNT_W      = 16,
    localparam int ADDR_W    = $clog2(REG_NUMBER)
) (
    input  logic                clk,
    input  logic                rst,
    writeback_sequencer_if.slave up,
    output logic                rf_write_enable,
    output logic [ADDR_W-1:0]   rf_write_addr,
    output logic [REG_SIZE-1:0] rf_write_data,
    output logic                pend_hi_valid,
    output logic [ADDR_W-1:0]   pend_hi_addr,
    output logic [CNT_W-1:0]    retired_count
);

    wb_state_e           state;
    wb_state_e           state_next;
    logic                accept;
    logic [REG_SIZE-1:0] lo_data;
    logic [ADDR_W-1:0]   dst_plus1;
    logic [ADDR_W-1:0]   hi_addr;
    logic [REG_SIZE-1:0] hi_data;

    assign accept = up.in_valid && (state != DUAL_LO);

    // Explicit compare keeps the wrap correct for non-power-of-two register counts.
    assign dst_plus1 = (up.in_dst == ADDR_W'(REG_NUMBER - 1)) ? '0 : up.in_dst + 1'b1;

    always_comb begin
        // NOTE: default assignment first so no path leaves the output unassigned (no latch).
        lo_data = up.in_alu_lo;
        case (up.in_src_sel)
            SRC_MEM:  lo_data = up.in_mem_data;
            SRC_PORT: lo_data = up.in_port_data;
            SRC_IMM:  lo_data = up.in_imm;
            default:  lo_data = up.in_alu_lo;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = IDLE;
        if (state == DUAL_LO)
            state_next = DUAL_HI;
        else if (accept && up.in_wb_en)
            state_next = up.in_dual ? DUAL_LO : SINGLE;
    end

    always_comb begin
        rf_write_enable = (state != IDLE);
        up.in_ready     = (state != DUAL_LO);
        pend_hi_valid   = (state == DUAL_LO);
        pend_hi_addr    = (state == DUAL_LO) ? hi_addr : '0;
    end

    // Write-port registers: the rf_* bus never sees the inputs combinationally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_write_addr <= '0;
            rf_write_data <= '0;
            hi_addr       <= '0;
            hi_data       <= '0;
        end else if (state == DUAL_LO) begin
            rf_write_addr <= hi_addr;
            rf_write_data <= hi_data;
        end else if (accept && up.in_wb_en) begin
            rf_write_addr <= up.in_dst;
            if (up.in_dual) begin
                rf_write_data <= up.in_alu_lo;
                hi_addr       <= dst_plus1;
                hi_data       <= up.in_alu_hi;
            end else begin
                rf_write_data <= lo_data;
            end
        end
    end

    wrap_counter #(.WIDTH(CNT_W)) u_retired (
        .clk   (clk),
        .rst   (rst),
        .en    (accept),
        .count (retired_count)
    );

endmodule

// File: tb/tb_writeback_sequencer.sv
// Directed bench for writeback_sequencer with a negedge-commit register-file model.
module tb_writeback_sequencer;
    import wb_pkg::*;

    localparam int REG_SIZE = 16;
    localparam int ADDR_W   = 3;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic                rf_write_enable, rf_write_enable4;
    logic [ADDR_W-1:0]   rf_write_addr, rf_write_addr4;
    logic [REG_SIZE-1:0] rf_write_data, rf_write_data4;
    logic                pend_hi_valid, pend_hi_valid4;
    logic [ADDR_W-1:0]   pend_hi_addr, pend_hi_addr4;
    logic [15:0]         retired_count;
    logic [3:0]          retired_count4;
    logic [REG_SIZE-1:0] rf [8];

    writeback_sequencer_if #(.REG_SIZE(REG_SIZE), .ADDR_W(ADDR_W)) bus ();
    writeback_sequencer_if #(.REG_SIZE(REG_SIZE), .ADDR_W(ADDR_W)) bus4 ();

    writeback_sequencer #(.REG_SIZE(16), .REG_NUMBER(8), .CNT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .up              (bus.slave),
        .rf_write_enable (rf_write_enable),
        .rf_write_addr   (rf_write_addr),
        .rf_write_data   (rf_write_data),
        .pend_hi_valid   (pend_hi_valid),
        .pend_hi_addr    (pend_hi_addr),
        .retired_count   (retired_count)
    );

    writeback_sequencer #(.REG_SIZE(16), .REG_NUMBER(8), .CNT_W(4)) dut4 (
        .clk             (clk),
        .rst             (rst),
        .up              (bus4.slave),
        .rf_write_enable (rf_write_enable4),
        .rf_write_addr   (rf_write_addr4),
        .rf_write_data   (rf_write_data4),
        .pend_hi_valid   (pend_hi_valid4),
        .pend_hi_addr    (pend_hi_addr4),
        .retired_count   (retired_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file commits at the negedge inside the write cycle.
    always @(negedge clk) begin
        if (rf_write_enable === 1'b1)
            rf[rf_write_addr] <= rf_write_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic en, input logic dual, input logic [1:0] sel,
                         input logic [2:0] dst, input logic [15:0] lo, input logic [15:0] hi,
                         input logic [15:0] mem, input logic [15:0] port, input logic [15:0] imm);
        bus.in_valid     = v;
        bus.in_wb_en     = en;
        bus.in_dual      = dual;
        bus.in_src_sel   = sel;
        bus.in_dst       = dst;
        bus.in_alu_lo    = lo;
        bus.in_alu_hi    = hi;
        bus.in_mem_data  = mem;
        bus.in_port_data = port;
        bus.in_imm       = imm;
    endtask

    task automatic to_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 8; i++) rf[i] = 16'hF000 + 16'(i);

        bus4.in_valid = 1'b0; bus4.in_wb_en = 1'b0; bus4.in_dual = 1'b0;
        bus4.in_src_sel = SRC_ALU; bus4.in_dst = '0; bus4.in_alu_lo = '0;
        bus4.in_alu_hi = '0; bus4.in_mem_data = '0; bus4.in_port_data = '0; bus4.in_imm = '0;

        // Reset held two cycles with a valid write offered.
        rst = 1'b0;
        drive(1, 1, 0, SRC_IMM, 3'd5, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555);
        to_pos(); to_pos();
        to_neg();
        check("rst_we",    32'(rf_write_enable), 32'd0);
        check("rst_addr",  32'(rf_write_addr),   32'd0);
        check("rst_data",  32'(rf_write_data),   32'd0);
        check("rst_pend",  32'(pend_hi_valid),   32'd0);
        check("rst_paddr", 32'(pend_hi_addr),    32'd0);
        check("rst_cnt",   32'(retired_count),   32'd0);
        check("rst_ready", 32'(bus.in_ready),    32'd1);
        check("rst_rf5",   32'(rf[5]),           32'hF005);

        // Single write from memory source.
        rst = 1'b1;
        drive(1, 1, 0, SRC_MEM, 3'd3, 16'h0A0A, 16'h0B0B, 16'hBEEF, 16'h0C0C, 16'h0D0D);
        to_pos();
        bus.in_valid = 1'b0;
        to_neg();
        check("s_we",   32'(rf_write_enable), 32'd1);
        check("s_addr", 32'(rf_write_addr),   32'd3);
        check("s_data", 32'(rf_write_data),   32'hBEEF);
        check("s_rf3",  32'(rf[3]),           32'hBEEF);
        check("s_cnt",  32'(retired_count),   32'd1);

        // Dual at dst=7 wraps hi to r0; next instruction waits through the stall.
        drive(1, 1, 1, SRC_MEM, 3'd7, 16'h1234, 16'hABCD, 16'h9999, 16'h8888, 16'h7777);
        to_pos();
        drive(1, 1, 0, SRC_ALU, 3'd4, 16'h4444, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        to_neg();
        check("d1_we",    32'(rf_write_enable), 32'd1);
        check("d1_addr",  32'(rf_write_addr),   32'd7);
        check("d1_data",  32'(rf_write_data),   32'h1234);
        check("d1_pend",  32'(pend_hi_valid),   32'd1);
        check("d1_paddr", 32'(pend_hi_addr),    32'd0);
        check("d1_ready", 32'(bus.in_ready),    32'd0);
        check("d1_cnt",   32'(retired_count),   32'd2);
        to_neg();
        check("d2_we",    32'(rf_write_enable), 32'd1);
        check("d2_addr",  32'(rf_write_addr),   32'd0);
        check("d2_data",  32'(rf_write_data),   32'hABCD);
        check("d2_pend",  32'(pend_hi_valid),   32'd0);
        check("d2_ready", 32'(bus.in_ready),    32'd1);
        check("d2_cnt",   32'(retired_count),   32'd2);
        check("d2_rf7",   32'(rf[7]),           32'h1234);
        check("d2_rf0",   32'(rf[0]),           32'hABCD);
        to_pos();
        bus.in_valid = 1'b0;
        to_neg();
        check("d3_addr", 32'(rf_write_addr), 32'd4);
        check("d3_data", 32'(rf_write_data), 32'h4444);
        check("d3_cnt",  32'(retired_count), 32'd3);

        // No-write instruction, then back-to-back singles.
        drive(1, 0, 0, SRC_IMM, 3'd6, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0077);
        to_pos();
        drive(1, 1, 0, SRC_IMM, 3'd1, 16'h00F1, 16'h00F2, 16'h00F3, 16'h00F4, 16'h0005);
        to_neg();
        check("nw_we",  32'(rf_write_enable), 32'd0);
        check("nw_cnt", 32'(retired_count),   32'd4);
        check("nw_rf6", 32'(rf[6]),           32'hF006);
        to_pos();
        drive(1, 1, 0, SRC_PORT, 3'd2, 16'h00E1, 16'h00E2, 16'h00E3, 16'h0009, 16'h00E5);
        to_neg();
        check("b1_we",   32'(rf_write_enable), 32'd1);
        check("b1_addr", 32'(rf_write_addr),   32'd1);
        check("b1_data", 32'(rf_write_data),   32'h0005);
        to_pos();
        bus.in_valid = 1'b0;
        to_neg();
        check("b2_we",   32'(rf_write_enable), 32'd1);
        check("b2_addr", 32'(rf_write_addr),   32'd2);
        check("b2_data", 32'(rf_write_data),   32'h0009);
        check("b2_cnt",  32'(retired_count),   32'd6);
        check("b2_rf1",  32'(rf[1]),           32'h0005);
        to_neg();
        check("idle_we", 32'(rf_write_enable), 32'd0);

        // Reset while in DUAL_LO drops the pending hi write to r6.
        drive(1, 1, 1, SRC_ALU, 3'd5, 16'h5555, 16'h6666, 16'h0000, 16'h0000, 16'h0000);
        to_pos();
        bus.in_valid = 1'b0;
        to_neg();
        check("md_pend", 32'(pend_hi_valid), 32'd1);
        check("md_paddr", 32'(pend_hi_addr), 32'd6);
        rst = 1'b0;
        to_pos();
        rst = 1'b1;
        to_neg();
        check("md_we",    32'(rf_write_enable), 32'd0);
        check("md_pend0", 32'(pend_hi_valid),   32'd0);
        check("md_addr",  32'(rf_write_addr),   32'd0);
        check("md_data",  32'(rf_write_data),   32'd0);
        check("md_cnt",   32'(retired_count),   32'd0);
        check("md_ready", 32'(bus.in_ready),    32'd1);
        check("md_rf5",   32'(rf[5]),           32'h5555);
        to_neg(); to_neg();
        check("md_rf6",   32'(rf[6]),           32'hF006);

        // 4-bit counter wraps after 16 accepts.
        to_pos();
        bus4.in_valid = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("w_15", 32'(retired_count4), 32'd15);
        to_pos();
        check("w_16", 32'(retired_count4), 32'd0);
        to_pos();
        bus4.in_valid = 1'b0;
        check("w_17", 32'(retired_count4), 32'd1);
        to_pos();
        check("w_hold", 32'(retired_count4), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
